mouse_pacer: RTL

MOUSE_PACER -- requirements
Module: mouse_pacer

---
 rtl/ql_mouse_pkg.sv | 27 ++
 rtl/mouse_fifo.sv | 63 ++++++
 rtl/mouse_pacer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ql_mouse_pkg.sv
// Shared definitions for the mouse pacer: packet bit layout, FIFO entry
// format and scheduler state encoding.
package ql_mouse_pkg;

    localparam int PKT_W   = 25;
    localparam int ENTRY_W = 21;

    localparam int STB_BIT  = 24;
    localparam int DY_LO    = 16;
    localparam int DX_LO    = 8;
    localparam int DY_SIGN  = 5;
    localparam int DX_SIGN  = 4;
    localparam int BTN_LO   = 0;

    typedef struct packed {
        logic [2:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mouse_fifo.sv
// Circular FIFO of motion entries with an extra port that overwrites the
// newest entry, used to fold new motion into a full queue.
module mouse_fifo
    import ql_mouse_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cep,
    input  logic               push,
    input  logic               pop,
    input  logic               coalesce,
    input  logic [ENTRY_W-1:0] din,
    input  logic [ENTRY_W-1:0] cdata,
    output logic [ENTRY_W-1:0] head,
    output logic [ENTRY_W-1:0] newest,
    output logic               full,
    output logic               empty,
    output logic [4:0]         level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] ONE = 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    assign full   = (level == 5'(DEPTH));
    assign empty  = (level == 5'd0);
    assign head   = mem[rd_ptr];
    assign newest = mem[wr_ptr - ONE];

    // Storage carries no reset; only pointers and occupancy define contents.
    always_ff @(posedge clk) begin
        if (!reset && cep) begin
            if (push)
                mem[wr_ptr] <= din;
            else if (coalesce)
                mem[wr_ptr - ONE] <= cdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (cep) begin
            if (push)
                wr_ptr <= wr_ptr + ONE;
            if (pop)
                rd_ptr <= rd_ptr + ONE;
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mouse_pacer.sv
// Buffers host mouse events and re-emits them as packets whose deltas never
// exceed MAXSTEP, spaced GAP+1 cep cycles apart.
module mouse_pacer
    import ql_mouse_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAXSTEP = 32,
    parameter int GAP     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cep,
    input  logic [24:0] in_pkt,
    output logic [24:0] out_pkt,
    output logic [4:0]  level,
    output logic        ovf,
    output logic [1:0]  state
);

    localparam logic signed [9:0] MAX_POS = 10'(MAXSTEP);
    localparam logic signed [9:0] MAX_NEG = -MAX_POS;

    // Returns {saturated, sum} for two 9-bit two's complement values.
    function automatic logic [9:0] sat_add(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = {a[8], a} + {b[8], b};
        if (s[9] != s[8])
            return {1'b1, (s[9] ? 9'h100 : 9'h0FF)};
        return {1'b0, s[8:0]};
    endfunction

    function automatic logic signed [9:0] clamp(input logic signed [9:0] v);
        if (v > MAX_POS)
            return MAX_POS;
        if (v < MAX_NEG)
            return MAX_NEG;
        return v;
    endfunction

    state_t            st;
    logic signed [9:0] rem_x, rem_y;
    logic [2:0]        btn;
    logic [11:0]       cnt;
    logic              prev_stb;

    logic [ENTRY_W-1:0] head, newest;
    logic               full, empty;
    entry_t             in_e, head_e, newest_e, merged_e;
    logic [9:0]         sum_x, sum_y;
    logic               evt, pop, push, coalesce, rem_zero;
    logic signed [9:0]  chunk_x, chunk_y;
    logic [24:0]        next_pkt;
    logic               unused_bits;

    assign unused_bits = ^{in_pkt[7:6], in_pkt[3]};
    assign state       = st;

    assign in_e.btn = in_pkt[BTN_LO +: 3];
    assign in_e.dx  = {in_pkt[DX_SIGN], in_pkt[DX_LO +: 8]};
    assign in_e.dy  = {in_pkt[DY_SIGN], in_pkt[DY_LO +: 8]};
    assign head_e   = head;
    assign newest_e = newest;

    assign sum_x        = sat_add(newest_e.dx, in_e.dx);
    assign sum_y        = sat_add(newest_e.dy, in_e.dy);
    assign merged_e.btn = in_e.btn;
    assign merged_e.dx  = sum_x[8:0];
    assign merged_e.dy  = sum_y[8:0];

    assign rem_zero = (rem_x == 10'sd0) && (rem_y == 10'sd0);
    // The head leaves the FIFO exactly when the scheduler loads a new entry.
    assign pop      = cep && !empty &&
                      ((st == ST_IDLE) || (st == ST_WAIT && cnt == 12'd1 && rem_zero));
    assign evt      = cep && (in_pkt[STB_BIT] != prev_stb);
    assign push     = evt && (!full || pop);
    assign coalesce = evt && full && !pop;

    assign chunk_x = clamp(rem_x);
    assign chunk_y = clamp(rem_y);

    always_comb begin
        next_pkt                  = '0;
        next_pkt[STB_BIT]         = ~out_pkt[STB_BIT];
        next_pkt[DY_LO +: 8]      = chunk_y[7:0];
        next_pkt[DX_LO +: 8]      = chunk_x[7:0];
        next_pkt[DY_SIGN]         = chunk_y[9];
        next_pkt[DX_SIGN]         = chunk_x[9];
        next_pkt[BTN_LO +: 3]     = btn;
    end

    mouse_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .cep      (cep),
        .push     (push),
        .pop      (pop),
        .coalesce (coalesce),
        .din      (in_e),
        .cdata    (merged_e),
        .head     (head),
        .newest   (newest),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    // Tracks the strobe even in reset so release never looks like an event.
    always_ff @(posedge clk) begin
        if (reset || cep)
            prev_stb <= in_pkt[STB_BIT];
    end

    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (coalesce && (sum_x[9] || sum_y[9]))
            ovf <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= ST_IDLE;
            rem_x   <= '0;
            rem_y   <= '0;
            btn     <= '0;
            cnt     <= '0;
            out_pkt <= '0;
        end else if (cep) begin
            case (st)
                ST_IDLE: begin
                    if (pop) begin
                        rem_x <= signed'({head_e.dx[8], head_e.dx});
                        rem_y <= signed'({head_e.dy[8], head_e.dy});
                        btn   <= head_e.btn;
                        st    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    out_pkt <= next_pkt;
                    rem_x   <= rem_x - chunk_x;
                    rem_y   <= rem_y - chunk_y;
                    cnt     <= 12'(GAP);
                    st      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == 12'd1) begin
                        if (!rem_zero) begin
                            st <= ST_EMIT;
                        end else if (pop) begin
                            rem_x <= signed'({head_e.dx[8], head_e.dx});
                            rem_y <= signed'({head_e.dy[8], head_e.dy});
                            btn   <= head_e.btn;
                            st    <= ST_EMIT;
                        end else begin
                            st <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
